// File: rtl/vip_pkg.sv
// -----------------------------------------------------------------------------
// vip_pkg
// Shared types and widths for the edge-detector frame controller.
//   state_t   : frame FSM states (IDLE / ACTIVE / UPDATE)
//   THRESH_W  : width of the Sobel threshold
//   CNT_W     : width of the per-frame pixel and edge counters
//   sat_inc() : counter increment that holds at all-ones
// -----------------------------------------------------------------------------
package vip_pkg;

    localparam int THRESH_W = 11;
    localparam int CNT_W    = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Increment when en is set, but never wrap past 2^CNT_W-1.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/vip_edge_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// vip_edge_frame_ctrl_if
// Bundles the detector output stream, the host threshold-write handshake and
// the per-frame statistics of vip_edge_frame_ctrl.
//   Stream in  : post_frame_vsync, post_frame_href, post_frame_clken, post_edge
//   Config     : cfg_valid, cfg_thresh[10:0] in; cfg_ready out
//   Results    : sobel_threshold[10:0], frame_done, edge_count[19:0],
//                frame_err, frame_busy
// Modports: master = detector/host side, slave = the controller.
// -----------------------------------------------------------------------------
interface vip_edge_frame_ctrl_if;
    import vip_pkg::*;

    logic                post_frame_vsync;
    logic                post_frame_href;
    logic                post_frame_clken;
    logic                post_edge;
    logic                cfg_valid;
    logic [THRESH_W-1:0] cfg_thresh;
    logic                cfg_ready;
    logic [THRESH_W-1:0] sobel_threshold;
    logic                frame_done;
    logic [CNT_W-1:0]    edge_count;
    logic                frame_err;
    logic                frame_busy;

    modport master (
        output post_frame_vsync, post_frame_href, post_frame_clken, post_edge,
        output cfg_valid, cfg_thresh,
        input  cfg_ready, sobel_threshold, frame_done, edge_count,
        input  frame_err, frame_busy
    );

    modport slave (
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_edge,
        input  cfg_valid, cfg_thresh,
        output cfg_ready, sobel_threshold, frame_done, edge_count,
        output frame_err, frame_busy
    );

endinterface

// File: rtl/vip_sat_step.sv
// -----------------------------------------------------------------------------
// vip_sat_step
// Combinational threshold step: +STEP when up, -STEP when down (up wins),
// result clamped to [MIN, MAX]; otherwise passes thresh through.
//   thresh   in  THRESH_W  current threshold
//   up       in  1         request an increase
//   down     in  1         request a decrease
//   next     out THRESH_W  stepped threshold
// -----------------------------------------------------------------------------
module vip_sat_step
    import vip_pkg::*;
#(
    parameter int STEP = 8,
    parameter int MIN  = 16,
    parameter int MAX  = 1023
) (
    input  logic [THRESH_W-1:0] thresh,
    input  logic                up,
    input  logic                down,
    output logic [THRESH_W-1:0] next
);

    // One extra bit so thresh + STEP cannot wrap before it is compared.
    localparam logic [THRESH_W:0] STEP_X = (THRESH_W+1)'(STEP);
    localparam logic [THRESH_W:0] MIN_X  = (THRESH_W+1)'(MIN);
    localparam logic [THRESH_W:0] MAX_X  = (THRESH_W+1)'(MAX);

    logic [THRESH_W:0] thresh_x;
    logic [THRESH_W:0] sum_x;

    assign thresh_x = {1'b0, thresh};
    assign sum_x    = thresh_x + STEP_X;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next = thresh;
        if (up) begin
            next = (sum_x > MAX_X) ? MAX_X[THRESH_W-1:0] : sum_x[THRESH_W-1:0];
        end else if (down) begin
            // Compare before subtracting so small values never underflow.
            next = (thresh_x < MIN_X + STEP_X) ? MIN_X[THRESH_W-1:0]
                                               : thresh - STEP_X[THRESH_W-1:0];
        end
    end

endmodule

// File: rtl/vip_edge_frame_ctrl.sv
// -----------------------------------------------------------------------------
// vip_edge_frame_ctrl
// Frame-level controller for a Sobel edge detector: counts qualified and edge
// pixels per frame, publishes the counts at each vsync rising edge, and owns
// the threshold fed back to the detector (host writes, optional auto-adjust).
//   clk    in  pixel clock
//   rst_n  in  asynchronous active-low reset
//   vif    vip_edge_frame_ctrl_if.slave (stream, config handshake, results)
// Optional feature: define VIP_AUTO_THRESH_EN to step the threshold each frame
// toward the [EDGE_LO, EDGE_HI] edge-count window when no host value is queued.
// -----------------------------------------------------------------------------
module vip_edge_frame_ctrl
    import vip_pkg::*;
#(
    parameter int IMG_W          = 640,
    parameter int IMG_H          = 480,
    parameter int THRESH_DEFAULT = 250,
    parameter int THRESH_MIN     = 16,
    parameter int THRESH_MAX     = 1023,
    parameter int EDGE_LO        = 8000,
    parameter int EDGE_HI        = 40000,
    parameter int THRESH_STEP    = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    vip_edge_frame_ctrl_if.slave vif
);

    localparam logic [CNT_W-1:0]    FRAME_PIX  = CNT_W'(IMG_W * IMG_H);
    localparam logic [THRESH_W-1:0] THRESH_RST = THRESH_W'(THRESH_DEFAULT);

    state_t              state, state_nxt;
    logic                vsync_d;
    logic                vs_rise;
    logic                pix_ok, edge_ok;
    logic [CNT_W-1:0]    pix_cnt, edge_cnt;
    logic                carry_pix, carry_edge;
    logic [CNT_W-1:0]    edge_count_q;
    logic                frame_err_q, frame_done_q;
    logic [THRESH_W-1:0] thresh_q, thresh_nxt;
    logic                pend_valid;
    logic [THRESH_W-1:0] pend_val;
    logic                accept;

    assign vs_rise = vif.post_frame_vsync & ~vsync_d;
    assign pix_ok  = vif.post_frame_href & vif.post_frame_clken;
    assign edge_ok = pix_ok & vif.post_edge;
    assign accept  = vif.cfg_valid & ~pend_valid;

    // ---------------------------------------------------------------- FSM
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= vif.post_frame_vsync;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = ACTIVE;
            ACTIVE:  if (vs_rise) state_nxt = UPDATE;
            UPDATE:  state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ counters
    // A pixel seen in the vs_rise cycle is parked in carry_* and, together with
    // any pixel in the UPDATE cycle, seeds the new frame's counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            edge_cnt   <= '0;
            carry_pix  <= 1'b0;
            carry_edge <= 1'b0;
        end else begin
            carry_pix  <= 1'b0;
            carry_edge <= 1'b0;
            case (state)
                IDLE: begin
                    pix_cnt  <= vs_rise ? CNT_W'(pix_ok)  : '0;
                    edge_cnt <= vs_rise ? CNT_W'(edge_ok) : '0;
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        carry_pix  <= pix_ok;
                        carry_edge <= edge_ok;
                    end else begin
                        pix_cnt  <= sat_inc(pix_cnt, pix_ok);
                        edge_cnt <= sat_inc(edge_cnt, edge_ok);
                    end
                end
                UPDATE: begin
                    pix_cnt  <= CNT_W'(carry_pix)  + CNT_W'(pix_ok);
                    edge_cnt <= CNT_W'(carry_edge) + CNT_W'(edge_ok);
                end
                default: begin
                    pix_cnt  <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- threshold
`ifdef VIP_AUTO_THRESH_EN
    logic [THRESH_W-1:0] thresh_auto;

    vip_sat_step #(
        .STEP (THRESH_STEP),
        .MIN  (THRESH_MIN),
        .MAX  (THRESH_MAX)
    ) u_sat_step (
        .thresh (thresh_q),
        .up     (edge_cnt > CNT_W'(EDGE_HI)),
        .down   (edge_cnt < CNT_W'(EDGE_LO)),
        .next   (thresh_auto)
    );

    always_comb begin
        thresh_nxt = pend_valid ? pend_val : thresh_auto;
    end
`else
    always_comb begin
        thresh_nxt = pend_valid ? pend_val : thresh_q;
    end
`endif

    // Host pending slot: freed by the UPDATE that applies it, so cfg_ready
    // reasserts the cycle after UPDATE. A write landing in an UPDATE with the
    // slot already free is simply queued for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_val   <= '0;
        end else if ((state == UPDATE) && pend_valid) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_val   <= vif.cfg_thresh;
        end
    end

    // ------------------------------------------------------ frame results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count_q <= '0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            thresh_q     <= THRESH_RST;
        end else begin
            frame_done_q <= (state == UPDATE);
            if (state == UPDATE) begin
                edge_count_q <= edge_cnt;
                frame_err_q  <= (pix_cnt != FRAME_PIX);
                thresh_q     <= thresh_nxt;
            end
        end
    end

    assign vif.cfg_ready       = ~pend_valid;
    assign vif.sobel_threshold = thresh_q;
    assign vif.frame_done      = frame_done_q;
    assign vif.edge_count      = edge_count_q;
    assign vif.frame_err       = frame_err_q;
    assign vif.frame_busy      = (state == ACTIVE);

endmodule

// File: doc/vip_edge_frame_ctrl.md
VIP_EDGE_FRAME_CTRL -- requirements
Module: vip_edge_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  IMG_W, 640, active pixels per line.
  IMG_H, 480, active lines per frame.
  THRESH_DEFAULT, 250, threshold value loaded at reset.
  THRESH_MIN / THRESH_MAX, 16 / 1023, saturation bounds for the auto-adjust step.
  EDGE_LO / EDGE_HI, 8000 / 40000, per-frame edge-count target window for auto-adjust.
  THRESH_STEP, 8, auto-adjust increment per frame.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  Ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock.
  rst_n  in  1  async active-low reset.
  post_frame_vsync  in  1  detector output vsync.
  post_frame_href  in  1  detector output line valid.
  post_frame_clken  in  1  detector output pixel enable.
  post_edge  in  1  detector edge bit, bit 0 of post_img_bit.
  cfg_valid  in  1  host threshold write request.
  cfg_thresh  in  11  requested threshold.
  cfg_ready  out  1  pending slot free.
  sobel_threshold  out  11  threshold driven to the detector.
  frame_done  out  1  one-cycle pulse at each frame boundary.
  edge_count  out  20  edge pixels counted in the last completed frame.
  frame_err  out  1  last frame's pixel count differed from IMG_W*IMG_H.
  frame_busy  out  1  FSM is in ACTIVE.

Function
REQ-003 Frame boundary: a rising edge of post_frame_vsync, detected with one register stage (vs_rise = vsync & ~vsync_d).
REQ-004 FSM states: IDLE, ACTIVE, UPDATE. Transitions:
  IDLE→ACTIVE on the first vs_rise; no stats are published.
  ACTIVE→UPDATE on vs_rise.
  UPDATE→ACTIVE unconditionally after 1 cycle.
REQ-005 Pixel counting: in ACTIVE, the pixel counter (20 b) increments when post_frame_href & post_frame_clken; edge_cnt increments when the pixel condition holds and post_edge=1; both saturate at 2^20-1.
REQ-006 In UPDATE, the block shall, all on the same edge:
  load edge_count ← edge_cnt;
  set frame_err ← (pixel count ≠ IMG_W*IMG_H);
  pulse frame_done=1;
  clear both counters;
  update sobel_threshold per REQ-008/REQ-010.
  Outputs are visible 2 clk after the cycle vsync is first sampled high.
REQ-007 A pixel qualified in the vs_rise cycle or the UPDATE cycle shall be counted in the new frame, not lost.
REQ-008 Config handshake: a write is accepted when cfg_valid & cfg_ready, storing cfg_thresh in the pending register; cfg_ready then deasserts until the next UPDATE applies it (sobel_threshold ← pending), and reasserts the cycle after UPDATE.
REQ-009 A cfg_valid that coincides with UPDATE while cfg_ready=1 shall be accepted into pending and applied at the following frame boundary.
REQ-010 Host-pending threshold has priority over auto-adjust in the same UPDATE.
REQ-011 sobel_threshold shall only change in UPDATE and never mid-frame.
REQ-012 frame_busy=1 iff state==ACTIVE.

Reset
REQ-013 On rst_n low, asynchronously:
  state=IDLE;
  counters=0;
  edge_count=0;
  frame_err=0;
  frame_done=0;
  sobel_threshold=THRESH_DEFAULT;
  pending cleared;
  cfg_ready=1.
REQ-014 Reset mid-frame discards partial statistics; the first frame after reset is never reported.

Configuration
REQ-015 Macro VIP_AUTO_THRESH_EN, when defined: in UPDATE with no host pending value:
  edge_cnt>EDGE_HI → threshold += THRESH_STEP, saturating at THRESH_MAX;
  edge_cnt<EDGE_LO → threshold -= THRESH_STEP, saturating at THRESH_MIN;
  otherwise unchanged.
REQ-016 When VIP_AUTO_THRESH_EN is undefined, sobel_threshold changes only via host writes; the EDGE_*, THRESH_MIN/MAX and THRESH_STEP parameters are unused.

Structure
REQ-017 Package vip_pkg holds:
  the FSM state typedef (IDLE/ACTIVE/UPDATE);
  THRESH_W=11;
  CNT_W=20.
REQ-018 One sub-module, vip_sat_step, is natural: a combinational saturating add/subtract of THRESH_STEP within [THRESH_MIN, THRESH_MAX]. Everything else stays in vip_edge_frame_ctrl.

Verification
REQ-019 Directed scenarios (stimulus -> required response):
  Reset, then two frames of 640x480 with post_edge=0 -> first frame_done at the second vs_rise; edge_count=0; frame_err=0; sobel_threshold=250.
  Frame with 1000 edge pixels and 639x480 pixels -> edge_count=1000, frame_err=1.
  cfg write of 300 mid-frame -> cfg_ready=0 until UPDATE; threshold 250→300 exactly at frame_done; cfg_ready=1 on the next cycle.
  Second cfg_valid while cfg_ready=0 -> not accepted; the first value is retained.
  Auto (macro on), edge_cnt=50000 with threshold 1020 -> 1023 (saturated); edge_cnt=100 with threshold 20 -> 16.
  rst_n pulsed low mid-frame -> all outputs at reset values immediately; no frame_done until two vs_rise later.
